calculator_ctrl: RTL and testbench
==================================

# calculator_ctrl

Operation sequencer between the board inputs and the iterative calculator datapath. It debounces the `button` input and captures `func`/`num1`/`num2` on each accepted press. It launches the datapath through a start/done handshake, guards against divide-by-zero and a hung datapath, and holds the result and status for the display driver. It runs in the divided `clk_g` domain alongside the datapath and display.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 20000: consecutive stable cycles required before the filtered button level changes.
- `TIMEOUT_CYCLES`, 64: maximum number of cycles to wait for `op_done` after `op_start`.

Ports:
- `clk`  in  1  system clock (divided `clk_g`); one clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `button`  in  1  raw push button, asynchronous to `clk`.
- `func`  in  3  operation select. 0 add, 1 sub, 2 mul, 3 div, 4 mod, 5 shl, 6 shr, 7 clear.
- `num1`, `num2`  in  8 each  operands A and B.
- `op_start`  out  1  one-cycle launch pulse to the datapath.
- `op_func`  out  3  registered operation; stable from `op_start` until completion.
- `op_a`, `op_b`  out  8 each  registered operands; stable from `op_start` until completion.
- `op_done`  in  1  datapath completion pulse.
- `op_result`  in  32  datapath result; valid in the `op_done` cycle.
- `op_err`  in  1  datapath error flag; valid in the `op_done` cycle.
- `cal_result`  out  32  held result presented to the display.
- `result_valid`  out  1  `cal_result` holds a completed result.
- `busy`  out  1  an operation is in flight.
- `error`  out  1  the last operation failed.

## Operation
- Button path:
  - 2-FF synchronizer feeds the debounce filter.
  - The filtered level toggles only after the synchronized input differs from it for `DEBOUNCE_CYCLES` consecutive cycles. Any bounce restarts the count.
  - A rising edge of the filtered level produces a one-cycle `press` event.
- FSM states: IDLE, LAUNCH, WAIT.
  - IDLE, on `press`:
    - `func`=7: clear. `cal_result`=0, `result_valid`=0, `error`=0. Stay in IDLE; no `op_start`.
    - `func`∈{3,4} and `num2`=0: `cal_result`=32'hEEEE_EEEE, `error`=1, `result_valid`=1. Stay in IDLE; no launch.
    - Otherwise: capture `op_func`/`op_a`/`op_b`, then go to LAUNCH.
  - LAUNCH: `op_start`=1 for exactly this cycle; clear the timeout counter; go to WAIT.
  - WAIT:
    - On `op_done`: `cal_result`=`op_result`, `error`=`op_err`, `result_valid`=1; go to IDLE.
    - If `TIMEOUT_CYCLES` elapse without `op_done`: `cal_result`=32'hEEEE_EEEE, `error`=1, `result_valid`=1; go to IDLE.
- `busy` = (state ≠ IDLE), registered.
- Presses while `busy` are dropped, not queued.
- `op_done` outside WAIT is ignored.
- `op_done` in the same cycle as the timeout: `op_done` wins.
- Operands are zero-extended by the datapath. The controller performs no arithmetic; the width rule is 8-bit in, 32-bit out.
- A new successful result overwrites `cal_result` and clears `error`.

## Timing
- Reset (asynchronous, immediate): state IDLE; all outputs 0, including `cal_result`, `op_func`/`op_a`/`op_b`, `result_valid`, `busy`, `error` and the debounce counter. The filtered level resets to 0.
- Raw button rising edge held clean: `press` follows 2 + `DEBOUNCE_CYCLES` cycles later. `op_start` follows the cycle after `press` (LAUNCH); `busy` rises together with `op_start`.
- Earliest `op_done` is sampled the cycle after `op_start`. `cal_result`/`result_valid` update the cycle after `op_done` is sampled, and `busy` falls in that same cycle.
- The timeout fires in the cycle when the counter reaches `TIMEOUT_CYCLES` after `op_start`.
- Clear and divide-by-zero results appear one cycle after `press`.
- Reset mid-WAIT: the operation is abandoned. A late `op_done` after reset release is ignored because the FSM is in IDLE.

## Structure
- Package `calc_pkg` holds:
  - func codes (`FUNC_ADD` … `FUNC_CLR`);
  - FSM state encoding;
  - `ERR_PATTERN` = 32'hEEEE_EEEE.
- Sub-module `btn_debounce` (synchronizer, counter, edge detect → `press`), parameterised by `DEBOUNCE_CYCLES`.
- Top level holds the FSM, the operand/result registers and the timeout counter.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `TIMEOUT_CYCLES`=8.
- Clean press, func=0, num1=8'h12, num2=8'h34; model replies `op_done` 3 cycles after `op_start` with result 32'h46 → exactly one `op_start`, with `op_a`=8'h12 and `op_b`=8'h34; `cal_result`=32'h46, `result_valid`=1, `error`=0, `busy` low afterwards.
- Button bouncing 1-0-1 at 2-cycle intervals, then held high 4 cycles → exactly one `press` and one `op_start`.
- func=3, num2=0 → no `op_start`; `cal_result`=32'hEEEE_EEEE and `error`=1 one cycle after `press`.
- Model never asserts `op_done` → error pattern with `error`=1 eight cycles after `op_start`. A second press during WAIT produces no second `op_start`.
- func=7 press after a valid result → `cal_result`=0, `result_valid`=0, `error`=0.
- Assert `rst` two cycles into WAIT, release, then the model pulses `op_done` → all outputs 0 and no `result_valid`.

Source files
------------

// File: rtl/calculator_ctrl_pkg.sv
// Shared definitions for the calculator operation sequencer: function codes,
// FSM state encoding and the error display pattern.
package calc_pkg;

    typedef enum logic [2:0] {
        FUNC_ADD = 3'd0,
        FUNC_SUB = 3'd1,
        FUNC_MUL = 3'd2,
        FUNC_DIV = 3'd3,
        FUNC_MOD = 3'd4,
        FUNC_SHL = 3'd5,
        FUNC_SHR = 3'd6,
        FUNC_CLR = 3'd7
    } func_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    localparam logic [31:0] ERR_PATTERN = 32'hEEEE_EEEE;

    // Division and modulo are the only operations that cannot take a zero B.
    function automatic logic needs_nonzero_b(logic [2:0] f);
        return (f == FUNC_DIV) || (f == FUNC_MOD);
    endfunction

endpackage

// File: rtl/calculator_ctrl_if.sv
// Launch/completion handshake between the sequencer (master) and the
// iterative calculator datapath (slave).
interface calculator_ctrl_if;

    logic        op_start;
    logic [2:0]  op_func;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        op_done;
    logic [31:0] op_result;
    logic        op_err;

    modport master (
        output op_start, op_func, op_a, op_b,
        input  op_done, op_result, op_err
    );

    modport slave (
        input  op_start, op_func, op_a, op_b,
        output op_done, op_result, op_err
    );

endinterface

// File: rtl/calculator_ctrl_btn_debounce.sv
// Push-button conditioning: 2-FF synchronizer, stable-count filter and a
// registered one-cycle pulse on each rising edge of the filtered level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    // Any cycle where the synchronized input agrees with the filtered level
    // restarts the count, so only an unbroken run of disagreement toggles it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
                press <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/calculator_ctrl.sv
// Operation sequencer: accepts debounced button presses, launches the datapath
// and holds the result and status for the display driver.
module calculator_ctrl
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               button,
    input  logic [2:0]         func,
    input  logic [7:0]         num1,
    input  logic [7:0]         num2,
    calculator_ctrl_if.master  dp,
    output logic [31:0]        cal_result,
    output logic               result_valid,
    output logic               busy,
    output logic               error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    // The counter starts one cycle after op_start, so expiry is two counts
    // early to land exactly TIMEOUT_CYCLES cycles after the launch pulse.
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 2);

    logic          press;
    state_t        state;
    logic [TW-1:0] tmo_cnt;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .button(button),
        .press (press)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            tmo_cnt      <= '0;
            dp.op_start  <= 1'b0;
            dp.op_func   <= '0;
            dp.op_a      <= '0;
            dp.op_b      <= '0;
            cal_result   <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            error        <= 1'b0;
        end else begin
            dp.op_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (press) begin
                        if (func == FUNC_CLR) begin
                            cal_result   <= '0;
                            result_valid <= 1'b0;
                            error        <= 1'b0;
                        end else if (needs_nonzero_b(func) && (num2 == 8'd0)) begin
                            cal_result   <= ERR_PATTERN;
                            result_valid <= 1'b1;
                            error        <= 1'b1;
                        end else begin
                            dp.op_func  <= func;
                            dp.op_a     <= num1;
                            dp.op_b     <= num2;
                            dp.op_start <= 1'b1;
                            busy        <= 1'b1;
                            state       <= ST_LAUNCH;
                        end
                    end
                end
                ST_LAUNCH: begin
                    tmo_cnt <= '0;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Completion is checked first so a simultaneous timeout loses.
                    if (dp.op_done) begin
                        cal_result   <= dp.op_result;
                        error        <= dp.op_err;
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= ST_IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        cal_result   <= ERR_PATTERN;
                        error        <= 1'b1;
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calculator_ctrl.sv
// Self-checking bench for calculator_ctrl with a behavioural datapath model
// and a result/status reference model computed from the operation rules.
module tb_calculator_ctrl;

    localparam int D = 4;
    localparam int T = 8;
    localparam int PRESS_IDX = 3 + D;
    localparam int WIN = 22;
    localparam logic [31:0] ERR_VAL = 32'hEEEE_EEEE;

    logic        clk;
    logic        rst;
    logic        button;
    logic [2:0]  func;
    logic [7:0]  num1;
    logic [7:0]  num2;
    logic [31:0] cal_result;
    logic        result_valid;
    logic        busy;
    logic        error;

    calculator_ctrl_if dp_if ();

    calculator_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .button      (button),
        .func        (func),
        .num1        (num1),
        .num2        (num2),
        .dp          (dp_if),
        .cal_result  (cal_result),
        .result_valid(result_valid),
        .busy        (busy),
        .error       (error)
    );

    int total = 0;
    int bad = 0;
    int start_count = 0;
    int dp_delay = -1;
    logic dp_err = 1'b0;

    logic [31:0] m_result = '0;
    logic        m_valid = 1'b0;
    logic        m_error = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dp_if.op_start === 1'b1) start_count <= start_count + 1;
    end

    function automatic logic [31:0] dp_calc(logic [2:0] f, logic [7:0] a, logic [7:0] b);
        logic [31:0] xa;
        logic [31:0] xb;
        xa = {24'd0, a};
        xb = {24'd0, b};
        case (f)
            3'd0: return xa + xb;
            3'd1: return xa - xb;
            3'd2: return xa * xb;
            3'd3: return (xb == 0) ? ERR_VAL : xa / xb;
            3'd4: return (xb == 0) ? ERR_VAL : xa % xb;
            3'd5: return xa << xb;
            3'd6: return xa >> xb;
            default: return 32'd0;
        endcase
    endfunction

    // Datapath model: answers dp_delay cycles after each launch pulse.
    initial begin
        int d;
        logic [2:0] cf;
        logic [7:0] ca;
        logic [7:0] cb;
        dp_if.op_done   = 1'b0;
        dp_if.op_result = '0;
        dp_if.op_err    = 1'b0;
        forever begin
            @(negedge clk);
            if (dp_if.op_start === 1'b1 && dp_delay > 0) begin
                d  = dp_delay;
                cf = dp_if.op_func;
                ca = dp_if.op_a;
                cb = dp_if.op_b;
                repeat (d) @(negedge clk);
                dp_if.op_done   = 1'b1;
                dp_if.op_result = dp_calc(cf, ca, cb);
                dp_if.op_err    = dp_err;
                @(negedge clk);
                dp_if.op_done   = 1'b0;
                dp_if.op_result = '0;
                dp_if.op_err    = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic releaseButton();
        button = 1'b0;
        repeat (D + 4) @(negedge clk);
    endtask

    // One clean press; expectations come from the operation rules and the
    // datapath reply (delay in cycles after op_start, -1 for never).
    task automatic applyStimulus(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                                 input int delay, input logic err);
        int s0;
        int vis;
        logic launch;
        logic [31:0] e_result;
        logic        e_valid;
        logic        e_error;
        s0 = start_count;
        launch = 1'b0;
        if (f == 3'd7) begin
            e_result = 32'd0; e_valid = 1'b0; e_error = 1'b0; vis = PRESS_IDX;
        end else if ((f == 3'd3 || f == 3'd4) && b == 8'd0) begin
            e_result = ERR_VAL; e_valid = 1'b1; e_error = 1'b1; vis = PRESS_IDX;
        end else begin
            launch = 1'b1;
            e_valid = 1'b1;
            if (delay >= 1 && delay <= T - 1) begin
                e_result = dp_calc(f, a, b); e_error = err; vis = PRESS_IDX + delay + 1;
            end else begin
                e_result = ERR_VAL; e_error = 1'b1; vis = PRESS_IDX + T;
            end
        end
        func = f; num1 = a; num2 = b; dp_delay = delay; dp_err = err;
        @(negedge clk);
        button = 1'b1;
        for (int idx = 1; idx <= WIN; idx++) begin
            @(negedge clk);
            if (launch && idx == PRESS_IDX) begin
                checkOutput("op_start", {31'd0, dp_if.op_start}, 32'd1);
                checkOutput("busy_rise", {31'd0, busy}, 32'd1);
                checkOutput("op_func", {29'd0, dp_if.op_func}, {29'd0, f});
                checkOutput("op_a", {24'd0, dp_if.op_a}, {24'd0, a});
                checkOutput("op_b", {24'd0, dp_if.op_b}, {24'd0, b});
            end
            if (idx == vis - 1) begin
                checkOutput("held_result", cal_result, m_result);
                checkOutput("held_valid", {31'd0, result_valid}, {31'd0, m_valid});
                if (launch) checkOutput("busy_before", {31'd0, busy}, 32'd1);
            end
            if (idx == vis) begin
                checkOutput("cal_result", cal_result, e_result);
                checkOutput("error", {31'd0, error}, {31'd0, e_error});
                checkOutput("result_valid", {31'd0, result_valid}, {31'd0, e_valid});
                checkOutput("busy_after", {31'd0, busy}, 32'd0);
            end
        end
        releaseButton();
        checkOutput("start_count", start_count - s0, launch ? 32'd1 : 32'd0);
        m_result = e_result; m_valid = e_valid; m_error = e_error;
    endtask

    task automatic bounceTest();
        int s0;
        s0 = start_count;
        func = 3'd2; num1 = 8'd9; num2 = 8'd7; dp_delay = 3; dp_err = 1'b0;
        @(negedge clk);
        for (int idx = 0; idx <= WIN; idx++) begin
            if (idx == 0) button = 1'b1;
            if (idx == 2) button = 1'b0;
            if (idx == 4) button = 1'b1;
            @(negedge clk);
        end
        releaseButton();
        checkOutput("bounce_starts", start_count - s0, 32'd1);
        checkOutput("bounce_result", cal_result, 32'd63);
        checkOutput("bounce_valid", {31'd0, result_valid}, 32'd1);
        m_result = 32'd63; m_valid = 1'b1; m_error = 1'b0;
    endtask

    // Launch that never completes, with a second press landing during WAIT.
    task automatic dropTest();
        int s0;
        s0 = start_count;
        func = 3'd0; num1 = 8'd1; num2 = 8'd2; dp_delay = -1; dp_err = 1'b0;
        @(negedge clk);
        button = 1'b1;
        for (int idx = 1; idx <= WIN; idx++) begin
            @(negedge clk);
            if (idx == 4) button = 1'b0;
            if (idx == 8) button = 1'b1;
            if (idx == PRESS_IDX + T - 1) checkOutput("drop_busy", {31'd0, busy}, 32'd1);
            if (idx == PRESS_IDX + T) begin
                checkOutput("tmo_result", cal_result, ERR_VAL);
                checkOutput("tmo_error", {31'd0, error}, 32'd1);
                checkOutput("tmo_valid", {31'd0, result_valid}, 32'd1);
                checkOutput("tmo_busy", {31'd0, busy}, 32'd0);
            end
        end
        releaseButton();
        checkOutput("drop_starts", start_count - s0, 32'd1);
        m_result = ERR_VAL; m_valid = 1'b1; m_error = 1'b1;
    endtask

    task automatic resetTest();
        int s0;
        s0 = start_count;
        func = 3'd1; num1 = 8'h50; num2 = 8'h10; dp_delay = 6; dp_err = 1'b0;
        @(negedge clk);
        button = 1'b1;
        for (int idx = 1; idx <= WIN; idx++) begin
            @(negedge clk);
            if (idx == PRESS_IDX + 2) begin
                button = 1'b0;
                rst = 1'b1;
                #1;
                checkOutput("rst_async_busy", {31'd0, busy}, 32'd0);
                checkOutput("rst_async_a", {24'd0, dp_if.op_a}, 32'd0);
            end
            if (idx == PRESS_IDX + 3) rst = 1'b0;
        end
        checkOutput("rst_result", cal_result, 32'd0);
        checkOutput("rst_valid", {31'd0, result_valid}, 32'd0);
        checkOutput("rst_error", {31'd0, error}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_opfunc", {29'd0, dp_if.op_func}, 32'd0);
        checkOutput("rst_starts", start_count - s0, 32'd1);
        m_result = '0; m_valid = 1'b0; m_error = 1'b0;
    endtask

    initial begin
        rst = 1'b1; button = 1'b0; func = '0; num1 = '0; num2 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_result", cal_result, 32'd0);
        checkOutput("reset_valid", {31'd0, result_valid}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_error", {31'd0, error}, 32'd0);
        checkOutput("reset_start", {31'd0, dp_if.op_start}, 32'd0);
        checkOutput("reset_opa", {24'd0, dp_if.op_a}, 32'd0);

        applyStimulus(3'd0, 8'h12, 8'h34, 3, 1'b0);
        bounceTest();
        applyStimulus(3'd3, 8'h55, 8'h00, 3, 1'b0);
        dropTest();
        applyStimulus(3'd2, 8'h0F, 8'h11, 7, 1'b0);
        applyStimulus(3'd7, 8'h00, 8'h00, 3, 1'b0);
        applyStimulus(3'd4, 8'hC8, 8'h07, 2, 1'b1);
        applyStimulus(3'd5, 8'h81, 8'h03, 8, 1'b0);

        for (int i = 0; i < 24; i++) begin
            logic [2:0] rf;
            logic [7:0] ra;
            logic [7:0] rb;
            int rd;
            rf = 3'($urandom_range(0, 7));
            ra = 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            rd = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(1, T + 1));
            applyStimulus(rf, ra, rb, rd, 1'($urandom_range(0, 1)));
        end

        resetTest();
        applyStimulus(3'd0, 8'hFF, 8'hFF, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
